// File: rtl/ace_ccu_snoop_gate.sv
// ace_ccu_snoop_gate
// Single-entry admission stage in front of the CCU conflict manager. It holds
// one snoop request, presents its line address to the conflict manager, and
// forwards the request downstream only once the line is free. The manager's
// ready is raised on the forwarding handshake, so the manager allocates the
// line exactly when the request leaves.
module ace_ccu_snoop_gate #(
    parameter int unsigned AxiAddrWidth  = 64,
    parameter int unsigned OffsetWidth   = 6,
    parameter int unsigned CmAddrWidth   = 32,
    parameter int unsigned PayloadWidth  = 8,
    parameter int unsigned StallCntWidth = 16,
    parameter int unsigned StallLimit    = 1024
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    // upstream request
    input  logic                     slv_valid_i,
    output logic                     slv_ready_o,
    input  logic [AxiAddrWidth-1:0]  slv_addr_i,
    input  logic [PayloadWidth-1:0]  slv_payload_i,
    // downstream request
    output logic                     mst_valid_o,
    input  logic                     mst_ready_i,
    output logic [AxiAddrWidth-1:0]  mst_addr_o,
    output logic [PayloadWidth-1:0]  mst_payload_o,
    // conflict manager
    output logic                     cm_snoop_valid_o,
    output logic                     cm_snoop_ready_o,
    output logic [CmAddrWidth-1:0]   cm_snoop_addr_o,
    input  logic                     cm_snoop_stall_i,
    // status
    output logic [StallCntWidth-1:0] stall_cnt_o,
    output logic                     starve_o,
    output logic                     protocol_err_o
);

    // EMPTY: no request held. HOLD: request held, line may be stalled.
    // SEND: mst_valid_o already raised, so it must stay up until accepted.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HOLD  = 2'd1,
        SEND  = 2'd2
    } state_e;

    localparam logic [StallCntWidth-1:0] StallLimitCnt = StallCntWidth'(StallLimit);
    localparam logic [StallCntWidth-1:0] StallCntMax   = '1;

    state_e                   r_state;
    state_e                   w_state_next;
    logic [AxiAddrWidth-1:0]  r_addr;
    logic [PayloadWidth-1:0]  r_payload;
    logic [StallCntWidth-1:0] r_stall_cnt;
    logic                     r_protocol_err;

    logic                     w_mst_valid;
    logic                     w_cm_ready;
    logic                     w_handshake;
    logic                     w_slv_ready;
    logic                     w_load;

    // A slot frees up either when it is empty or when the held request leaves
    // this very cycle, which gives full throughput with no bubble.
    assign w_handshake = w_mst_valid & mst_ready_i;
    assign w_slv_ready = (r_state == EMPTY) | w_handshake;
    assign w_load      = slv_valid_i & w_slv_ready;

    // Next-state and handshake outputs for the admission FSM.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned; an unassigned path in always_comb infers a latch.
        w_state_next = r_state;
        w_mst_valid  = 1'b0;
        w_cm_ready   = 1'b0;
        unique case (r_state)
            EMPTY: begin
                if (slv_valid_i) begin
                    w_state_next = HOLD;
                end
            end
            HOLD: begin
                w_mst_valid = ~cm_snoop_stall_i;
                w_cm_ready  = ~cm_snoop_stall_i & mst_ready_i;
                if (~cm_snoop_stall_i & mst_ready_i) begin
                    w_state_next = slv_valid_i ? HOLD : EMPTY;
                end else if (~cm_snoop_stall_i) begin
                    // Valid was shown downstream; it may not be withdrawn.
                    w_state_next = SEND;
                end
            end
            SEND: begin
                w_mst_valid = 1'b1;
                // A stall here means the line leaves without allocation; the
                // request still goes out and the error flag records it.
                w_cm_ready  = mst_ready_i & ~cm_snoop_stall_i;
                if (mst_ready_i) begin
                    w_state_next = slv_valid_i ? HOLD : EMPTY;
                end
            end
            default: begin
                w_state_next = EMPTY;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block evaluation order.
        if (!rst_ni) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Request holding register, loaded whenever a new request is accepted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: the data register is reset as well because its zero value is
        // visible on mst_addr_o/mst_payload_o straight out of reset.
        if (!rst_ni) begin
            r_addr    <= '0;
            r_payload <= '0;
        end else if (w_load) begin
            r_addr    <= slv_addr_i;
            r_payload <= slv_payload_i;
        end
    end

    // Consecutive stalled cycles of the held request, saturating, restarted
    // on every load.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_stall_cnt <= '0;
        end else if (w_load) begin
            r_stall_cnt <= '0;
        end else if ((r_state == HOLD) && cm_snoop_stall_i && (r_stall_cnt != StallCntMax)) begin
            r_stall_cnt <= r_stall_cnt + StallCntWidth'(1);
        end
    end

    // Sticky flag: conflict manager stalled a request already committed
    // downstream. Only reset clears it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_protocol_err <= 1'b0;
        end else if ((r_state == SEND) && cm_snoop_stall_i) begin
            r_protocol_err <= 1'b1;
        end
    end

    assign slv_ready_o      = w_slv_ready;
    assign mst_valid_o      = w_mst_valid;
    assign mst_addr_o       = r_addr;
    assign mst_payload_o    = r_payload;
    assign cm_snoop_valid_o = (r_state != EMPTY);
    assign cm_snoop_ready_o = w_cm_ready;
    assign cm_snoop_addr_o  = r_addr[OffsetWidth+CmAddrWidth-1:OffsetWidth];
    assign stall_cnt_o      = r_stall_cnt;
    assign starve_o         = (r_stall_cnt >= StallLimitCnt);
    assign protocol_err_o   = r_protocol_err;

endmodule

// File: tb/tb_ace_ccu_snoop_gate.sv
// Testbench for ace_ccu_snoop_gate. Directed stimulus pushes expected
// forwarded requests into a scoreboard queue; a monitor pops and compares on
// every downstream handshake. A second instance with a tiny stall counter
// covers starvation and saturation.
module tb_ace_ccu_snoop_gate;

    typedef struct {
        logic [63:0] addr;
        logic [7:0]  payload;
    } exp_t;

    logic clk;
    logic rst_n;

    // main instance (default parameters)
    logic        slv_valid;
    logic        slv_ready;
    logic [63:0] slv_addr;
    logic [7:0]  slv_payload;
    logic        mst_valid;
    logic        mst_ready;
    logic [63:0] mst_addr;
    logic [7:0]  mst_payload;
    logic        cm_valid;
    logic        cm_ready;
    logic [31:0] cm_addr;
    logic        cm_stall;
    logic [15:0] stall_cnt;
    logic        starve;
    logic        protocol_err;

    // small instance (StallLimit=3, StallCntWidth=2)
    logic        s_slv_valid;
    logic        s_slv_ready;
    logic [63:0] s_slv_addr;
    logic [7:0]  s_slv_payload;
    logic        s_mst_valid;
    logic        s_mst_ready;
    logic [63:0] s_mst_addr;
    logic [7:0]  s_mst_payload;
    logic        s_cm_valid;
    logic        s_cm_ready;
    logic [31:0] s_cm_addr;
    logic        s_cm_stall;
    logic [1:0]  s_stall_cnt;
    logic        s_starve;
    logic        s_protocol_err;

    int   n_cmp = 0;
    int   n_err = 0;
    int   n_hs  = 0;
    exp_t sb_q[$];

    ace_ccu_snoop_gate dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .slv_valid_i      (slv_valid),
        .slv_ready_o      (slv_ready),
        .slv_addr_i       (slv_addr),
        .slv_payload_i    (slv_payload),
        .mst_valid_o      (mst_valid),
        .mst_ready_i      (mst_ready),
        .mst_addr_o       (mst_addr),
        .mst_payload_o    (mst_payload),
        .cm_snoop_valid_o (cm_valid),
        .cm_snoop_ready_o (cm_ready),
        .cm_snoop_addr_o  (cm_addr),
        .cm_snoop_stall_i (cm_stall),
        .stall_cnt_o      (stall_cnt),
        .starve_o         (starve),
        .protocol_err_o   (protocol_err)
    );

    ace_ccu_snoop_gate #(
        .StallCntWidth (2),
        .StallLimit    (3)
    ) dut_s (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .slv_valid_i      (s_slv_valid),
        .slv_ready_o      (s_slv_ready),
        .slv_addr_i       (s_slv_addr),
        .slv_payload_i    (s_slv_payload),
        .mst_valid_o      (s_mst_valid),
        .mst_ready_i      (s_mst_ready),
        .mst_addr_o       (s_mst_addr),
        .mst_payload_o    (s_mst_payload),
        .cm_snoop_valid_o (s_cm_valid),
        .cm_snoop_ready_o (s_cm_ready),
        .cm_snoop_addr_o  (s_cm_addr),
        .cm_snoop_stall_i (s_cm_stall),
        .stall_cnt_o      (s_stall_cnt),
        .starve_o         (s_starve),
        .protocol_err_o   (s_protocol_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // inputs change 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // outputs are observed on the falling edge
    task automatic samp();
        @(negedge clk);
    endtask

    // Drive a request and confirm acceptance in this cycle; returns at the
    // falling edge with the expected forward already queued.
    task automatic issue(input logic [63:0] addr, input logic [7:0] pay);
        exp_t e;
        slv_valid   = 1'b1;
        slv_addr    = addr;
        slv_payload = pay;
        samp();
        check("accept", {63'd0, slv_ready}, 64'd1);
        e.addr    = addr;
        e.payload = pay;
        sb_q.push_back(e);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_slv_ready"}, {63'd0, slv_ready}, 64'd1);
        check({tag, "_mst_valid"}, {63'd0, mst_valid}, 64'd0);
        check({tag, "_cm_valid"}, {63'd0, cm_valid}, 64'd0);
        check({tag, "_cm_ready"}, {63'd0, cm_ready}, 64'd0);
        check({tag, "_stall_cnt"}, {48'd0, stall_cnt}, 64'd0);
        check({tag, "_starve"}, {63'd0, starve}, 64'd0);
        check({tag, "_perr"}, {63'd0, protocol_err}, 64'd0);
        check({tag, "_mst_addr"}, mst_addr, 64'd0);
        check({tag, "_mst_payload"}, {56'd0, mst_payload}, 64'd0);
    endtask

    // Scoreboard monitor: every downstream handshake must match the oldest
    // expected request, and the manager must allocate unless it is stalling.
    always @(negedge clk) begin
        if (rst_n && mst_valid && mst_ready) begin
            exp_t e;
            n_hs = n_hs + 1;
            if (sb_q.size() == 0) begin
                check("hs_unexpected", 64'd1, 64'd0);
            end else begin
                e = sb_q.pop_front();
                check("hs_addr", mst_addr, e.addr);
                check("hs_payload", {56'd0, mst_payload}, {56'd0, e.payload});
                check("hs_cm_addr", {32'd0, cm_addr}, {32'd0, e.addr[37:6]});
                check("hs_cm_ready", {63'd0, cm_ready}, {63'd0, ~cm_stall});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] addr_tbl [4];
        logic [7:0]  pay_tbl  [4];
        int          hs_start;
        int          exp_cnt;

        addr_tbl[0] = 64'h0000_0000_0000_7000; pay_tbl[0] = 8'hC1;
        addr_tbl[1] = 64'h0000_0000_0000_7040; pay_tbl[1] = 8'hC2;
        addr_tbl[2] = 64'hFFFF_0000_1234_5680; pay_tbl[2] = 8'hC3;
        addr_tbl[3] = 64'h0000_0000_0000_0000; pay_tbl[3] = 8'hC4;

        rst_n = 1'b0;
        slv_valid = 1'b0; slv_addr = '0; slv_payload = '0;
        mst_ready = 1'b0; cm_stall = 1'b0;
        s_slv_valid = 1'b0; s_slv_addr = '0; s_slv_payload = '0;
        s_mst_ready = 1'b0; s_cm_stall = 1'b0;

        // Reset values
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Free line: accepted in cycle 0, forwarded and allocated in cycle 1
        cm_stall  = 1'b0;
        mst_ready = 1'b1;
        issue(64'h1040, 8'hA5);
        tick();
        slv_valid = 1'b0;
        samp();
        check("free_mst_valid", {63'd0, mst_valid}, 64'd1);
        check("free_cm_addr", {32'd0, cm_addr}, 64'h41);
        check("free_cm_ready", {63'd0, cm_ready}, 64'd1);
        tick();
        samp();
        check("free_empty_mst_valid", {63'd0, mst_valid}, 64'd0);
        check("free_empty_slv_ready", {63'd0, slv_ready}, 64'd1);
        check("free_empty_cm_valid", {63'd0, cm_valid}, 64'd0);
        tick();

        // Conflict: five stalled cycles, forward in the cycle stall falls
        cm_stall = 1'b1;
        issue(64'h2080, 8'h11);
        tick();
        slv_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            samp();
            check("conf_mst_valid", {63'd0, mst_valid}, 64'd0);
            check("conf_slv_ready", {63'd0, slv_ready}, 64'd0);
            check("conf_cm_valid", {63'd0, cm_valid}, 64'd1);
            check("conf_stall_cnt", {48'd0, stall_cnt}, 64'(k));
            tick();
        end
        cm_stall = 1'b0;
        samp();
        check("conf_cnt_final", {48'd0, stall_cnt}, 64'd5);
        check("conf_fwd_valid", {63'd0, mst_valid}, 64'd1);
        check("conf_fwd_slv_ready", {63'd0, slv_ready}, 64'd1);
        tick();

        // Backpressure: valid and address stable, no allocation until ready
        mst_ready = 1'b0;
        issue(64'h3000C0, 8'h22);
        tick();
        slv_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            samp();
            check("bp_mst_valid", {63'd0, mst_valid}, 64'd1);
            check("bp_mst_addr", mst_addr, 64'h3000C0);
            check("bp_cm_ready", {63'd0, cm_ready}, 64'd0);
            tick();
        end
        mst_ready = 1'b1;
        samp();
        check("bp_release_cm_ready", {63'd0, cm_ready}, 64'd1);
        tick();

        // Back-to-back: four requests, four consecutive handshakes in order
        hs_start = n_hs;
        for (int i = 0; i < 4; i++) begin
            issue(addr_tbl[i], pay_tbl[i]);
            if (i > 0) begin
                check("b2b_mst_valid", {63'd0, mst_valid}, 64'd1);
            end
            tick();
        end
        slv_valid = 1'b0;
        samp();
        check("b2b_last_valid", {63'd0, mst_valid}, 64'd1);
        check("b2b_last_cnt", {48'd0, stall_cnt}, 64'd0);
        tick();
        check("b2b_hs_count", 64'(n_hs - hs_start), 64'd4);

        // Stall in SEND raises the sticky error but the request still leaves
        mst_ready = 1'b0;
        issue(64'h5000, 8'h33);
        tick();
        slv_valid = 1'b0;
        samp();
        check("err_hold_valid", {63'd0, mst_valid}, 64'd1);
        tick();
        cm_stall = 1'b1;
        samp();
        check("err_send_valid", {63'd0, mst_valid}, 64'd1);
        check("err_send_cm_ready", {63'd0, cm_ready}, 64'd0);
        tick();
        cm_stall = 1'b0;
        samp();
        check("err_set", {63'd0, protocol_err}, 64'd1);
        tick();
        mst_ready = 1'b1;
        samp();
        check("err_fwd_valid", {63'd0, mst_valid}, 64'd1);
        tick();
        mst_ready = 1'b0;
        samp();
        check("err_sticky", {63'd0, protocol_err}, 64'd1);
        tick();

        // Reset mid-HOLD discards the held request immediately
        cm_stall = 1'b1;
        issue(64'h6000, 8'h44);
        tick();
        slv_valid = 1'b0;
        samp();
        check("rst_pre_cnt", {48'd0, stall_cnt}, 64'd0);
        tick();
        samp();
        check("rst_pre_cm_valid", {63'd0, cm_valid}, 64'd1);
        #2;
        rst_n = 1'b0;
        sb_q.delete();
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        rst_n    = 1'b1;
        cm_stall = 1'b0;
        tick();

        // Starvation and saturation on the small-counter instance
        s_cm_stall    = 1'b1;
        s_mst_ready   = 1'b0;
        s_slv_valid   = 1'b1;
        s_slv_addr    = 64'h7780;
        s_slv_payload = 8'h55;
        samp();
        check("starve_accept", {63'd0, s_slv_ready}, 64'd1);
        tick();
        s_slv_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            exp_cnt = (k > 3) ? 3 : k;
            samp();
            check("starve_cnt", {62'd0, s_stall_cnt}, 64'(exp_cnt));
            check("starve_flag", {63'd0, s_starve}, (exp_cnt >= 3) ? 64'd1 : 64'd0);
            check("starve_mst_valid", {63'd0, s_mst_valid}, 64'd0);
            tick();
        end
        s_cm_stall  = 1'b0;
        s_mst_ready = 1'b1;
        samp();
        check("starve_fwd_valid", {63'd0, s_mst_valid}, 64'd1);
        check("starve_fwd_addr", s_mst_addr, 64'h7780);
        check("starve_fwd_payload", {56'd0, s_mst_payload}, 64'h55);
        tick();
        s_mst_ready = 1'b0;

        // Every expected forward must have been seen
        samp();
        check("sb_drain", 64'(sb_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
